udp_tx_sched: RTL and testbench

// - Two-requester frame scheduler in front of the RMII UDP transmitter (mac).
// - Owns the mac start strobe, UDP length and byte-data mux. Arbitrates round-robin between

---
 rtl/udp_sched_pkg.sv | 20 ++
 rtl/udp_tx_sched_rr_arb2.sv | 43 ++++
 rtl/udp_tx_sched.sv | 213 +++++++++++++++++++++
 tb/tb_udp_tx_sched.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_sched_pkg.sv
// Shared types and helpers for the UDP transmit scheduler: FSM state encoding
// and UDP length arithmetic.
package udp_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_BUSY,
    S_XFER,
    S_IFG
  } sched_state_t;

  localparam logic [15:0] UDP_HDR_LEN = 16'd8;

  // Length handed to the mac covers the 8-byte UDP header plus payload.
  function automatic logic [15:0] udp_len(input logic [15:0] payload);
    return payload + UDP_HDR_LEN;
  endfunction

endpackage

// File: rtl/udp_tx_sched_rr_arb2.sv
// Two-way round-robin arbiter. When both requests are active, the requester
// not granted last wins; prio_q names the requester preferred next.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       update_i,
  output logic [1:0] pick_o,
  output logic       prio_o
);

  logic prio_q;
  logic prio_d;

  always_comb begin
    pick_o = 2'b00;
    unique case (req_i)
      2'b01:   pick_o = 2'b01;
      2'b10:   pick_o = 2'b10;
      2'b11:   pick_o = prio_q ? 2'b10 : 2'b01;
      default: pick_o = 2'b00;
    endcase
  end

  // After a grant the other requester becomes the preferred one.
  always_comb begin
    prio_d = prio_q;
    if (update_i && (pick_o != 2'b00)) begin
      prio_d = ~pick_o[1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

  assign prio_o = prio_q;

endmodule

// File: rtl/udp_tx_sched.sv
// Two-requester frame scheduler in front of the RMII UDP mac: round-robin
// grant, start strobe, byte mux, inter-frame gap and busy watchdog.
module udp_tx_sched
  import udp_sched_pkg::*;
#(
  parameter int          IFG_CYCLES     = 48,
  parameter logic [15:0] MAX_PAYLOAD    = 16'd1464,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd400000
) (
  input  logic        I_clk50m,
  input  logic        I_rst,
  input  logic [1:0]  I_req,
  input  logic [15:0] I_len0,
  input  logic [15:0] I_len1,
  input  logic [7:0]  I_data0,
  input  logic [7:0]  I_data1,
  output logic [1:0]  O_grant,
  output logic [1:0]  O_rd,
  output logic [1:0]  O_done,
  output logic [1:0]  O_reject,
  output logic        O_mac_en,
  output logic [15:0] O_mac_udpLen,
  output logic [7:0]  O_mac_data,
  input  logic        I_mac_busy,
  input  logic        I_mac_isLoadData,
  output logic        O_err_timeout,
  output logic [15:0] O_frame_cnt,
  output logic [2:0]  O_state,
  output logic        O_rr_ptr
);

  // Handshake: a requester raises I_req[n] with I_lenN stable and holds it
  // until it sees O_done[n] or O_reject[n]. I_dataN is first-word-fall-through:
  // the byte on I_dataN is consumed in the clock O_rd[n] is high, and the next
  // byte must be presented from the following clock.

  sched_state_t state_q, state_d;
  logic [1:0]   grant_q, grant_d;
  logic [15:0]  len_q, len_d;
  logic [15:0]  udplen_q, udplen_d;
  logic [15:0]  cnt_q, cnt_d;
  logic [15:0]  frame_cnt_q, frame_cnt_d;
  logic [23:0]  tmr_q, tmr_d;
  logic         err_q, err_d;
  logic [1:0]   done_q, done_d;
  logic [1:0]   reject_q, reject_d;

  logic [1:0]   arb_req;
  logic [1:0]   arb_pick;
  logic         arb_update;
  logic [15:0]  pick_len;
  logic         pick_bad;
  logic [7:0]   gnt_data;
  logic         in_len;
  logic         wd_expired;
  logic         ifg_last;

  // Outside S_IDLE the arbiter sees only the current grant, so the update
  // strobe records the requester actually served.
  assign arb_req    = (state_q == S_IDLE) ? I_req : grant_q;
  assign arb_update = (state_d == S_IFG) && (state_q != S_IFG);

  rr_arb2 u_arb (
    .clk_i    (I_clk50m),
    .rst_ni   (I_rst),
    .req_i    (arb_req),
    .update_i (arb_update),
    .pick_o   (arb_pick),
    .prio_o   (O_rr_ptr)
  );

  assign pick_len   = arb_pick[1] ? I_len1 : I_len0;
  assign pick_bad   = (pick_len == 16'd0) || (pick_len > MAX_PAYLOAD);
  assign gnt_data   = grant_q[1] ? I_data1 : I_data0;
  assign in_len     = cnt_q < len_q;
  assign wd_expired = tmr_q == (TIMEOUT_CYCLES - 24'd1);
  assign ifg_last   = tmr_q == 24'(IFG_CYCLES - 1);

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    len_d       = len_q;
    udplen_d    = udplen_q;
    cnt_d       = cnt_q;
    frame_cnt_d = frame_cnt_q;
    tmr_d       = tmr_q;
    err_d       = err_q;
    done_d      = 2'b00;
    reject_d    = 2'b00;
    O_rd        = 2'b00;
    O_mac_en    = 1'b0;
    O_mac_data  = 8'h00;

    unique case (state_q)
      S_IDLE: begin
        if (arb_pick != 2'b00) begin
          if (pick_bad) begin
            // Skip the clock right after a reject so one request gives one pulse.
            if ((reject_q & arb_pick) == 2'b00) begin
              reject_d = arb_pick;
            end
          end else begin
            grant_d  = arb_pick;
            len_d    = pick_len;
            udplen_d = udp_len(pick_len);
            cnt_d    = 16'd0;
            tmr_d    = 24'd0;
            state_d  = S_START;
          end
        end
      end

      S_START: begin
        O_mac_en = 1'b1;
        tmr_d    = tmr_q + 24'd1;
        if (wd_expired) begin
          err_d   = 1'b1;
          done_d  = grant_q;
          grant_d = 2'b00;
          tmr_d   = 24'd0;
          state_d = S_IFG;
        end else begin
          state_d = S_WAIT_BUSY;
        end
      end

      S_WAIT_BUSY: begin
        tmr_d = tmr_q + 24'd1;
        if (wd_expired) begin
          err_d   = 1'b1;
          done_d  = grant_q;
          grant_d = 2'b00;
          tmr_d   = 24'd0;
          state_d = S_IFG;
        end else if (I_mac_busy) begin
          state_d = S_XFER;
        end
      end

      S_XFER: begin
        tmr_d = tmr_q + 24'd1;
        if (in_len) begin
          O_mac_data = gnt_data;
        end
        if (I_mac_isLoadData && in_len) begin
          O_rd  = grant_q;
          cnt_d = cnt_q + 16'd1;
        end
        // A busy fall in the same clock as expiry counts as a clean finish.
        if (!I_mac_busy) begin
          done_d      = grant_q;
          frame_cnt_d = frame_cnt_q + 16'd1;
          grant_d     = 2'b00;
          tmr_d       = 24'd0;
          state_d     = S_IFG;
        end else if (wd_expired) begin
          err_d   = 1'b1;
          done_d  = grant_q;
          grant_d = 2'b00;
          tmr_d   = 24'd0;
          state_d = S_IFG;
        end
      end

      S_IFG: begin
        tmr_d = tmr_q + 24'd1;
        if (ifg_last) begin
          tmr_d   = 24'd0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge I_clk50m or negedge I_rst) begin
    if (!I_rst) begin
      state_q     <= S_IDLE;
      grant_q     <= 2'b00;
      len_q       <= 16'd0;
      udplen_q    <= 16'd0;
      cnt_q       <= 16'd0;
      frame_cnt_q <= 16'd0;
      tmr_q       <= 24'd0;
      err_q       <= 1'b0;
      done_q      <= 2'b00;
      reject_q    <= 2'b00;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      len_q       <= len_d;
      udplen_q    <= udplen_d;
      cnt_q       <= cnt_d;
      frame_cnt_q <= frame_cnt_d;
      tmr_q       <= tmr_d;
      err_q       <= err_d;
      done_q      <= done_d;
      reject_q    <= reject_d;
    end
  end

  assign O_grant       = grant_q;
  assign O_done        = done_q;
  assign O_reject      = reject_q;
  assign O_mac_udpLen  = udplen_q;
  assign O_err_timeout = err_q;
  assign O_frame_cnt   = frame_cnt_q;
  assign O_state       = state_q;

endmodule

// File: tb/tb_udp_tx_sched.sv
// Directed bench for udp_tx_sched with a behavioural mac: busy two clocks
// after the start strobe, one load every four clocks.
module tb_udp_tx_sched;
  import udp_sched_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #10 clk = ~clk;

  logic [1:0]  req;
  logic [15:0] len0, len1;
  logic [7:0]  data0, data1;
  logic [1:0]  grant, rd, done, reject;
  logic        mac_en, mac_busy, mac_load, err_to, rr_ptr;
  logic [15:0] udp_len_o, frame_cnt;
  logic [7:0]  mac_data;
  logic [2:0]  state;

  udp_tx_sched #(
    .IFG_CYCLES     (48),
    .MAX_PAYLOAD    (16'd1464),
    .TIMEOUT_CYCLES (24'd1000)
  ) dut (
    .I_clk50m         (clk),
    .I_rst            (rst_n),
    .I_req            (req),
    .I_len0           (len0),
    .I_len1           (len1),
    .I_data0          (data0),
    .I_data1          (data1),
    .O_grant          (grant),
    .O_rd             (rd),
    .O_done           (done),
    .O_reject         (reject),
    .O_mac_en         (mac_en),
    .O_mac_udpLen     (udp_len_o),
    .O_mac_data       (mac_data),
    .I_mac_busy       (mac_busy),
    .I_mac_isLoadData (mac_load),
    .O_err_timeout    (err_to),
    .O_frame_cnt      (frame_cnt),
    .O_state          (state),
    .O_rr_ptr         (rr_ptr)
  );

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;
  always @(posedge clk) cyc++;

  // mac model
  logic never_busy = 1'b0;
  int   extra = 0;
  int   phase, dly, left;
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mac_busy = 1'b0;
      mac_load = 1'b0;
      phase    = 0;
      dly      = 0;
      left     = 0;
    end else begin
      mac_load = 1'b0;
      case (phase)
        0: if (mac_en === 1'b1 && !never_busy) begin
             left  = int'(udp_len_o) - 8 + extra;
             dly   = 2;
             phase = 1;
           end
        1: begin
             dly--;
             if (dly == 0) begin
               mac_busy = 1'b1;
               dly      = 3;
               phase    = 2;
             end
           end
        2: if (dly == 0) begin
             if (left > 0) begin
               mac_load = 1'b1;
               left--;
               dly = 3;
             end else begin
               mac_busy = 1'b0;
               phase    = 0;
             end
           end else begin
             dly--;
           end
        default: phase = 0;
      endcase
    end
  end

  // FWFT sources and monitor
  int pop0 = 0, pop1 = 0, rd0_cnt = 0, rd1_cnt = 0, en_cnt = 0, last_fall = -1;
  logic prev_busy = 1'b0;
  logic [7:0] cap_q[$];
  logic [1:0] grant_log[$];
  int         gap_q[$];
  assign data0 = 8'hA0 + pop0[7:0];
  assign data1 = 8'h50 + pop1[7:0];

  always @(negedge clk) begin
    #1;
    if (mac_load) cap_q.push_back(mac_data);
    if (rd[0]) begin rd0_cnt++; pop0++; end
    if (rd[1]) begin rd1_cnt++; pop1++; end
    if (mac_en) begin
      en_cnt++;
      grant_log.push_back(grant);
      if (last_fall >= 0) gap_q.push_back(cyc - last_fall);
    end
    if (prev_busy && !mac_busy) last_fall = cyc;
    prev_busy = mac_busy;
  end

  // scoreboard
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic wait_done(input logic [1:0] m, input int bound, input string tag);
    int k = 0;
    while (((done & m) == 2'b00) && (k < bound)) begin
      step(1);
      k++;
    end
    chk(tag, 32'((done & m) != 2'b00), 32'd1);
  endtask

  task automatic wait_idle(input int bound);
    int k = 0;
    while ((state != 3'(S_IDLE)) && (k < bound)) begin
      step(1);
      k++;
    end
    chk("reach_idle", 32'(state), 32'(S_IDLE));
  endtask

  task automatic check_bytes(input string tag, input int c0);
    int i = 0;
    chk({tag, "_nbytes"}, 32'(cap_q.size() - c0), 32'(exp_q.size()));
    while (exp_q.size() > 0) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      if (c0 + i < cap_q.size()) chk({tag, "_byte"}, 32'(cap_q[c0 + i]), 32'(e));
      i++;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(1);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  int e0, r0, r1, c0, p0, g0, gp0, t_en;

  initial begin
    rst_n = 1'b0;
    req   = 2'b00;
    len0  = 16'd0;
    len1  = 16'd0;
    step(2);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_state", 32'(state), 32'(S_IDLE));
    chk("rst_outs", 32'({rd, done, reject, mac_en, err_to}), 32'd0);
    chk("rst_udplen", 32'(udp_len_o), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_rr_ptr", 32'(rr_ptr), 32'd0);
    rst_n = 1'b1;
    step(1);

    // single requester 0, 10-byte payload
    e0 = en_cnt; r0 = rd0_cnt; c0 = cap_q.size(); p0 = pop0;
    len0 = 16'd10;
    req  = 2'b01;
    step(1);
    chk("t1_mac_en", 32'(mac_en), 32'd1);
    chk("t1_grant", 32'(grant), 32'd1);
    chk("t1_udplen", 32'(udp_len_o), 32'd18);
    wait_done(2'b01, 400, "t1_done");
    req = 2'b00;
    chk("t1_rd_count", 32'(rd0_cnt - r0), 32'd10);
    chk("t1_en_count", 32'(en_cnt - e0), 32'd1);
    chk("t1_frame_cnt", 32'(frame_cnt), 32'd1);
    chk("t1_grant_clr", 32'(grant), 32'd0);
    for (int i = 0; i < 10; i++) exp_q.push_back(8'hA0 + 8'(p0 + i));
    check_bytes("t1", c0);
    wait_idle(100);

    // both requesters held: alternation from a reset pointer, gap enforced
    apply_reset();
    g0 = grant_log.size(); gp0 = gap_q.size(); r0 = rd0_cnt; r1 = rd1_cnt;
    len0 = 16'd4;
    len1 = 16'd4;
    req  = 2'b11;
    for (int f = 0; f < 4; f++) begin
      wait_done(2'b11, 400, "t2_done");
      step(1);
    end
    req = 2'b00;
    chk("t2_nframes", 32'(grant_log.size() - g0), 32'd4);
    for (int f = 0; f < 4; f++) begin
      if (g0 + f < grant_log.size())
        chk("t2_grant_order", 32'(grant_log[g0 + f]), (f % 2 == 0) ? 32'd1 : 32'd2);
    end
    for (int j = gp0; j < gap_q.size(); j++) chk("t2_ifg_ge48", 32'(gap_q[j] >= 48), 32'd1);
    chk("t2_rd0", 32'(rd0_cnt - r0), 32'd8);
    chk("t2_rd1", 32'(rd1_cnt - r1), 32'd8);
    chk("t2_frame_cnt", 32'(frame_cnt), 32'd4);
    wait_idle(100);

    // rejects on requester 1: zero length and one past the maximum
    e0 = en_cnt;
    len1 = 16'd0;
    req  = 2'b10;
    step(1);
    chk("t3_rej_len0", 32'(reject), 32'd2);
    chk("t3_grant_len0", 32'(grant), 32'd0);
    req = 2'b00;
    step(1);
    chk("t3_rej_single", 32'(reject), 32'd0);
    len1 = 16'd1465;
    req  = 2'b10;
    step(1);
    chk("t3_rej_1465", 32'(reject), 32'd2);
    req = 2'b00;
    step(2);
    chk("t3_no_en", 32'(en_cnt - e0), 32'd0);
    chk("t3_grant", 32'(grant), 32'd0);
    chk("t3_state", 32'(state), 32'(S_IDLE));

    // watchdog: mac never raises busy
    never_busy = 1'b1;
    len0 = 16'd5;
    req  = 2'b01;
    step(1);
    t_en = cyc;
    chk("t4_mac_en", 32'(mac_en), 32'd1);
    wait_done(2'b01, 1200, "t4_done");
    chk("t4_abort_time", 32'(cyc - t_en), 32'd1000);
    chk("t4_err", 32'(err_to), 32'd1);
    chk("t4_frame_cnt", 32'(frame_cnt), 32'd4);
    req = 2'b00;
    never_busy = 1'b0;
    wait_idle(100);
    len0 = 16'd3;
    req  = 2'b01;
    wait_done(2'b01, 400, "t4_next_done");
    req = 2'b00;
    chk("t4_next_frame_cnt", 32'(frame_cnt), 32'd5);
    chk("t4_err_sticky", 32'(err_to), 32'd1);
    wait_idle(100);

    // mac loads 3 bytes past the payload
    extra = 3;
    r0 = rd0_cnt; c0 = cap_q.size(); p0 = pop0;
    len0 = 16'd6;
    req  = 2'b01;
    wait_done(2'b01, 400, "t5_done");
    req   = 2'b00;
    extra = 0;
    chk("t5_rd_count", 32'(rd0_cnt - r0), 32'd6);
    for (int i = 0; i < 6; i++) exp_q.push_back(8'hA0 + 8'(p0 + i));
    for (int i = 0; i < 3; i++) exp_q.push_back(8'h00);
    check_bytes("t5", c0);
    wait_idle(100);

    // reset in the middle of a transfer
    r1 = rd1_cnt;
    len1 = 16'd10;
    req  = 2'b10;
    begin
      int k = 0;
      while (!((state == 3'(S_XFER)) && (rd1_cnt - r1 >= 2)) && (k < 200)) begin
        step(1);
        k++;
      end
    end
    chk("t6_in_xfer", 32'(state), 32'(S_XFER));
    rst_n = 1'b0;
    #1;
    chk("t6_rst_grant", 32'(grant), 32'd0);
    chk("t6_rst_state", 32'(state), 32'(S_IDLE));
    chk("t6_rst_outs", 32'({rd, done, reject, mac_en, err_to}), 32'd0);
    chk("t6_rst_udplen_data", 32'({udp_len_o, mac_data}), 32'd0);
    chk("t6_rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("t6_rst_rr_ptr", 32'(rr_ptr), 32'd0);
    req = 2'b00;
    step(1);
    rst_n = 1'b1;
    step(1);
    r1 = rd1_cnt;
    req = 2'b10;
    step(1);
    chk("t6_grant", 32'(grant), 32'd2);
    chk("t6_udplen", 32'(udp_len_o), 32'd18);
    wait_done(2'b10, 400, "t6_done");
    req = 2'b00;
    chk("t6_rd_count", 32'(rd1_cnt - r1), 32'd10);
    chk("t6_frame_cnt", 32'(frame_cnt), 32'd1);
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
